// File: rtl/bless_router_param.sv
// bless_router_param: parametrised 2-stage bufferless deflection
// router for a 2D mesh (N=0,E=1,S=2,W=3 plus local inject/eject).
// Optional side buffer for deflected flits: define BLESS_SIDEBUF_EN.
// Ports: clk; n_rst (sync, active-low);
//   in_flits/out_flits: 4 mesh ports, port p at [p*FLIT_W +: FLIT_W];
//   inj_flit/inj_valid/inj_ready: local injection handshake;
//   ej_flit/ej_valid: registered ejection.
// Flit: {valid, age, dst_x, dst_y, payload}.
module bless_router_param #(
  parameter int DATA_W   = 64,
  parameter int AGE_W    = 8,
  parameter int COORD_W  = 3,
  parameter int NODE_X   = 0,
  parameter int NODE_Y   = 0,
  parameter int SB_DEPTH = 4,
  localparam int FLIT_W  = 1 + AGE_W + 2*COORD_W + DATA_W
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [4*FLIT_W-1:0] in_flits,
  output logic [4*FLIT_W-1:0] out_flits,
  input  logic [FLIT_W-1:0]   inj_flit,
  input  logic                inj_valid,
  output logic                inj_ready,
  output logic [FLIT_W-1:0]   ej_flit,
  output logic                ej_valid
);

  typedef struct packed {
    logic               v;
    logic [AGE_W-1:0]   age;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [DATA_W-1:0]  pl;
  } flit_t;

  localparam logic [COORD_W-1:0] NX = COORD_W'(NODE_X);
  localparam logic [COORD_W-1:0] NY = COORD_W'(NODE_Y);
  localparam int SB_PW = $clog2(SB_DEPTH);

  function automatic logic is_local(input flit_t f);
    return (f.dx == NX) && (f.dy == NY);
  endfunction

  // {has_dir, dir}: XY routing, X resolved first
  function automatic logic [2:0] route(input flit_t f);
    if (f.dx > NX)      return 3'b101;
    else if (f.dx < NX) return 3'b111;
    else if (f.dy > NY) return 3'b110;
    else if (f.dy < NY) return 3'b100;
    else                return 3'b000;
  endfunction

  function automatic flit_t age_up(input flit_t f);
    flit_t g;
    g = f;
    if (!(&f.age)) g.age = f.age + 1'b1;
    return g;
  endfunction

  flit_t [3:0]    s1;
  flit_t [3:0]    out_q;
  flit_t [3:0]    slot;
  flit_t [3:0]    arb;
  flit_t          ej_q;
  flit_t          ej_d;
  flit_t          sb_head;
  logic [SB_PW:0] sb_cnt;
  logic           ej_hit;
  logic [1:0]     ej_idx;
  logic [2:0]     cnt;
  logic           re;
  logic           rdy;
  logic           put_re;
  logic           put_inj;
  logic [1:0]     rank [4];
  logic [3:0]     taken;
  logic [2:0]     pd;
  logic [1:0]     op;

`ifdef BLESS_SIDEBUF_EN
  localparam logic [SB_PW:0] SB_FULL = (SB_PW+1)'(SB_DEPTH);
  flit_t            sb_mem [SB_DEPTH];
  logic [SB_PW-1:0] sb_rd;
  logic [SB_PW-1:0] sb_wr;
  logic             vic_v;
  logic [1:0]       vic_p;
  flit_t            vic_f;
  logic             push;
`endif

  always_comb begin
    ej_hit = 1'b0;
    ej_idx = '0;
    for (int p = 0; p < 4; p++)
      if (s1[p].v && is_local(s1[p]) &&
          (!ej_hit || s1[p].age > s1[ej_idx].age)) begin
        ej_hit = 1'b1;
        ej_idx = 2'(p);
      end
    ej_d = ej_hit ? s1[ej_idx] : '0;

    slot = s1;
    if (ej_hit) slot[ej_idx] = '0;
    cnt = '0;
    for (int p = 0; p < 4; p++)
      cnt = cnt + 3'(slot[p].v);

    // side-buffer head takes a free slot before local injection
    re  = (sb_cnt != '0) && (cnt != 3'd4);
    rdy = n_rst && (cnt + 3'(re) < 3'd4);
    put_re  = re;
    put_inj = inj_valid && rdy;
    for (int p = 0; p < 4; p++)
      if (!slot[p].v) begin
        if (put_re) begin
          slot[p]   = sb_head;
          slot[p].v = 1'b1;
          put_re    = 1'b0;
        end else if (put_inj) begin
          slot[p]     = inj_flit;
          slot[p].v   = 1'b1;
          slot[p].age = '0;
          put_inj     = 1'b0;
        end
      end

    // rank = number of valid slots that beat this one
    for (int p = 0; p < 4; p++) begin
      rank[p] = '0;
      for (int q = 0; q < 4; q++)
        if (q != p && slot[q].v &&
            (slot[q].age > slot[p].age ||
             (slot[q].age == slot[p].age && q < p)))
          rank[p] = rank[p] + 2'd1;
    end

`ifdef BLESS_SIDEBUF_EN
    vic_v = 1'b0;
    vic_p = '0;
    vic_f = '0;
`endif
    taken = '0;
    arb   = '0;
    pd    = '0;
    op    = '0;
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 4; p++)
        if (slot[p].v && rank[p] == 2'(r)) begin
          pd = route(slot[p]);
          if (pd[2] && !taken[pd[1:0]]) begin
            op = pd[1:0];
          end else begin
            for (int k = 3; k >= 0; k--)
              if (!taken[k]) op = 2'(k);
`ifdef BLESS_SIDEBUF_EN
            // rank order: the last deflected is the youngest
            vic_v = 1'b1;
            vic_p = op;
            vic_f = slot[p];
`endif
          end
          taken[op] = 1'b1;
          arb[op]   = age_up(slot[p]);
        end

`ifdef BLESS_SIDEBUF_EN
    push = vic_v && (sb_cnt != SB_FULL);
    if (push) arb[vic_p] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1    <= '0;
      out_q <= '0;
      ej_q  <= '0;
    end else begin
      s1    <= in_flits;
      out_q <= arb;
      ej_q  <= ej_d;
    end
  end

`ifdef BLESS_SIDEBUF_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < SB_DEPTH; i++)
        sb_mem[i] <= '0;
      sb_rd  <= '0;
      sb_wr  <= '0;
      sb_cnt <= '0;
    end else begin
      if (push) begin
        sb_mem[sb_wr] <= vic_f;
        sb_wr         <= sb_wr + 1'b1;
      end
      if (re) sb_rd <= sb_rd + 1'b1;
      if (push && !re)      sb_cnt <= sb_cnt + 1'b1;
      else if (re && !push) sb_cnt <= sb_cnt - 1'b1;
    end
  end
  assign sb_head = sb_mem[sb_rd];
`else
  // no side buffer: permanently empty
  assign sb_cnt  = '0;
  assign sb_head = '0;
`endif

  assign out_flits = out_q;
  assign ej_flit   = ej_q;
  assign ej_valid  = ej_q.v;
  assign inj_ready = rdy;

endmodule

// File: tb/tb_bless_router_param.sv
// tb_bless_router_param: table-driven scoreboard bench
// for bless_router_param at NODE=(1,1).
module tb_bless_router_param;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 3;
  localparam int FW = 1 + AW + 2*CW + DW;
  localparam int BW = 4*FW;
`ifdef BLESS_SIDEBUF_EN
  localparam int SBD = 2;
`else
  localparam int SBD = 4;
`endif

  typedef logic [FW-1:0] fl_t;
  typedef logic [BW-1:0] bus_t;
  typedef struct {
    bus_t in;
    fl_t  inj;
    logic inj_v;
    bus_t out;
    fl_t  ej;
    logic rdy;
  } vec_t;
  typedef struct {
    bus_t out;
    fl_t  ej;
  } exp_t;

  localparam fl_t Z = '0;

  logic clk = 1'b0;
  logic n_rst;
  bus_t in_flits;
  bus_t out_flits;
  fl_t  inj_flit;
  logic inj_valid;
  logic inj_ready;
  fl_t  ej_flit;
  logic ej_valid;

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  exp_t sbq[$];
  exp_t e;

  always #5 clk = ~clk;

  bless_router_param #(
    .DATA_W(DW), .AGE_W(AW), .COORD_W(CW),
    .NODE_X(1), .NODE_Y(1), .SB_DEPTH(SBD)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .in_flits(in_flits), .out_flits(out_flits),
    .inj_flit(inj_flit), .inj_valid(inj_valid),
    .inj_ready(inj_ready),
    .ej_flit(ej_flit), .ej_valid(ej_valid)
  );

  function automatic fl_t mk(input int v, input int age,
                             input int dx, input int dy,
                             input int pl);
    return {1'(v), AW'(age), CW'(dx), CW'(dy), DW'(pl)};
  endfunction

  function automatic bus_t pk(input fl_t n, input fl_t e_,
                              input fl_t s, input fl_t w);
    return {w, s, e_, n};
  endfunction

  task automatic check(input string nm, input bus_t act,
                       input bus_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input bus_t in, input fl_t inj,
                     input logic iv, input bus_t out,
                     input fl_t ej, input logic rdy);
    vec_t v;
    v.in = in; v.inj = inj; v.inj_v = iv;
    v.out = out; v.ej = ej; v.rdy = rdy;
    tbl.push_back(v);
  endtask

  initial begin
    n_rst = 1'b0;
    in_flits = '0;
    inj_flit = '0;
    inj_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      in_flits = BW'({$urandom(), $urandom(),
                      $urandom(), $urandom()});
      inj_flit = FW'($urandom());
      inj_valid = 1'($urandom());
      @(posedge clk); #1;
      check("rst_out", out_flits, '0);
      check("rst_ejv", BW'(ej_valid), '0);
      check("rst_rdy", BW'(inj_ready), '0);
    end
    in_flits = '0;
    inj_valid = 1'b0;
    n_rst = 1'b1;
    @(posedge clk); #1;

`ifndef BLESS_SIDEBUF_EN
    add(pk(Z, Z, Z, mk(1,5,3,1,'hA1)), Z, 0,
        pk(Z, mk(1,6,3,1,'hA1), Z, Z), Z, 1);
    add(pk(mk(1,9,3,1,'hB1), Z, mk(1,4,2,0,'hB2), Z), Z, 0,
        pk(mk(1,5,2,0,'hB2), mk(1,10,3,1,'hB1), Z, Z), Z, 1);
    add(pk(Z, mk(1,7,1,1,'hC1), Z, mk(1,2,1,1,'hC2)), Z, 0,
        pk(mk(1,3,1,1,'hC2), Z, Z, Z), mk(1,7,1,1,'hC1), 1);
    add(pk(mk(1,3,1,0,'hD0), mk(1,3,2,1,'hD1),
           mk(1,1,1,2,'hD2), mk(1,2,0,1,'hD3)),
        mk(1,0,3,3,'hDF), 1,
        pk(mk(1,4,1,0,'hD0), mk(1,4,2,1,'hD1),
           mk(1,2,1,2,'hD2), mk(1,3,0,1,'hD3)), Z, 0);
    add(pk(mk(1,6,1,0,'hE0), mk(1,15,3,3,'hE1),
           Z, mk(1,0,0,0,'hE3)),
        mk(0,9,1,2,'hE9), 1,
        pk(mk(1,7,1,0,'hE0), mk(1,15,3,3,'hE1),
           mk(1,1,1,2,'hE9), mk(1,1,0,0,'hE3)), Z, 1);
    add(pk(mk(1,2,3,1,'hF0), Z, Z, Z),
        mk(0,0,3,1,'hF9), 1,
        pk(mk(1,1,3,1,'hF9), mk(1,3,3,1,'hF0), Z, Z), Z, 1);
    add(pk(Z, mk(1,4,1,1,'h61), mk(1,4,1,1,'h62),
           mk(1,1,1,0,'h63)), Z, 0,
        pk(mk(1,5,1,1,'h62), mk(1,2,1,0,'h63), Z, Z),
        mk(1,4,1,1,'h61), 1);
    add('0, Z, 0, '0, Z, 1);
    add(pk(mk(1,1,1,1,'h80), mk(1,2,2,1,'h81),
           mk(1,3,1,2,'h82), mk(1,4,0,1,'h83)),
        mk(0,0,1,0,'h89), 1,
        pk(mk(1,1,1,0,'h89), mk(1,3,2,1,'h81),
           mk(1,4,1,2,'h82), mk(1,5,0,1,'h83)),
        mk(1,1,1,1,'h80), 1);
`else
    for (int k = 0; k < 3; k++)
      add(pk(mk(1,8,3,1,'h100+k), mk(1,6,3,1,'h200+k),
             mk(1,4,3,1,'h300+k), mk(1,2,3,1,'h400+k)),
          Z, 0,
          pk(mk(1,7,3,1,'h200+k), mk(1,9,3,1,'h100+k),
             mk(1,5,3,1,'h300+k),
             (k == 2) ? mk(1,3,3,1,'h402) : Z),
          Z, 0);
    add('0, Z, 0, pk(Z, mk(1,3,3,1,'h400), Z, Z), Z, 1);
    add('0, Z, 0, pk(Z, mk(1,3,3,1,'h401), Z, Z), Z, 1);
    add('0, Z, 0, '0, Z, 1);
`endif

    for (int i = 0; i <= tbl.size(); i++) begin
      in_flits = (i < tbl.size()) ? tbl[i].in : '0;
      if (i >= 1) begin
        inj_flit  = tbl[i-1].inj;
        inj_valid = tbl[i-1].inj_v;
      end else begin
        inj_flit  = '0;
        inj_valid = 1'b0;
      end
      if (i < tbl.size()) begin
        e.out = tbl[i].out;
        e.ej  = tbl[i].ej;
        sbq.push_back(e);
      end
      #1;
      if (i >= 1)
        check($sformatf("rdy%0d", i-1), BW'(inj_ready),
              BW'(tbl[i-1].rdy));
      @(posedge clk); #1;
      if (i >= 1) begin
        e = sbq.pop_front();
        check($sformatf("out%0d", i-1), out_flits, e.out);
        check($sformatf("ej%0d", i-1), BW'(ej_flit),
              BW'(e.ej));
        check($sformatf("ejv%0d", i-1), BW'(ej_valid),
              BW'(e.ej[FW-1]));
      end
    end
    inj_valid = 1'b0;

    in_flits = pk(Z, Z, Z, mk(1,5,3,1,'h77));
    @(posedge clk); #1;
    in_flits = '0;
    n_rst = 1'b0;
    @(posedge clk); #1;
    check("mid_out", out_flits, '0);
    check("mid_ejv", BW'(ej_valid), '0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("post_out", out_flits, '0);
    @(posedge clk); #1;
    check("post_out2", out_flits, '0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
